// File: rtl/rgb_color_centroid.sv
// Colour-box pixel classifier with per-frame hit centroid computed by a sequential restoring divider.
// Optional per-frame bounding box of hits is built when RGB_CENTROID_BBOX_EN is defined.
module rgb_color_centroid #(
  parameter int WIDTH     = 32,
  parameter int HEIGHT    = 32,
  parameter int R_MIN     = 128,
  parameter int G_MAX     = 96,
  parameter int B_MAX     = 96,
  parameter int MIN_COUNT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_valid,
  input  logic        sof,
  input  logic [7:0]  Rp,
  input  logic [7:0]  Gp,
  input  logic [7:0]  Bp,
  output logic        mask,
  output logic        mask_valid,
  output logic [8:0]  cent_x,
  output logic [8:0]  cent_y,
  output logic [18:0] blob_count,
  output logic        found,
  output logic        result_valid,
  output logic        busy,
  output logic        overrun,
  output logic [8:0]  bbox_min_col,
  output logic [8:0]  bbox_max_col,
  output logic [8:0]  bbox_min_row,
  output logic [8:0]  bbox_max_row
);

  localparam logic [8:0]  COL_LAST = 9'(WIDTH - 1);
  localparam logic [8:0]  ROW_LAST = 9'(HEIGHT - 1);
  localparam logic [7:0]  R_LO     = 8'(R_MIN);
  localparam logic [7:0]  G_HI     = 8'(G_MAX);
  localparam logic [7:0]  B_HI     = 8'(B_MAX);
  localparam logic [18:0] CNT_MIN  = 19'(MIN_COUNT);
  localparam logic [4:0]  STEPS    = 5'd28;

  typedef enum logic {ACCUM = 1'b0, DIV = 1'b1} state_t;

  // One restoring-division step: returns {remainder, quotient/dividend shift register}.
  function automatic logic [46:0] div_step(input logic [18:0] rem, input logic [27:0] quo,
                                           input logic [18:0] den);
    logic [19:0] trial;
    logic [18:0] diff;
    trial = {rem, quo[27]};
    diff  = 19'(trial - {1'b0, den});
    if (trial >= {1'b0, den}) div_step = {diff, quo[26:0], 1'b1};
    else                      div_step = {trial[18:0], quo[26:0], 1'b0};
  endfunction

  function automatic logic [8:0] sat_pos(input logic [27:0] q);
    if (|q[27:9]) sat_pos = 9'h1FF;
    else          sat_pos = q[8:0];
  endfunction

  state_t      state, state_nxt;
  logic [8:0]  col, row;
  logic [27:0] sum_col, sum_row;
  logic [18:0] count;

  logic        hit_p0, last_p0, frame_end, start_div, drop, div_done, fin_found;
  logic [8:0]  pos_col_p0, pos_row_p0, col_nxt, row_nxt;
  logic [27:0] sum_col_nxt, sum_row_nxt;
  logic [18:0] count_nxt;

  logic [18:0] rem_x, rem_y, den;
  logic [27:0] quo_x, quo_y;
  logic [4:0]  step;

  // Pixel stage p0: classify, locate and fold the incoming pixel into the running sums.
  always_comb begin
    hit_p0      = (Rp >= R_LO) && (Gp <= G_HI) && (Bp <= B_HI);
    pos_col_p0  = sof ? 9'd0 : col;
    pos_row_p0  = sof ? 9'd0 : row;
    last_p0     = (pos_col_p0 == COL_LAST) && (pos_row_p0 == ROW_LAST);
    col_nxt     = pos_col_p0 + 9'd1;
    row_nxt     = pos_row_p0;
    if (pos_col_p0 == COL_LAST) begin
      col_nxt = 9'd0;
      row_nxt = (pos_row_p0 == ROW_LAST) ? 9'd0 : pos_row_p0 + 9'd1;
    end
    sum_col_nxt = (sof ? 28'd0 : sum_col) + (hit_p0 ? {19'd0, pos_col_p0} : 28'd0);
    sum_row_nxt = (sof ? 28'd0 : sum_row) + (hit_p0 ? {19'd0, pos_row_p0} : 28'd0);
    count_nxt   = (sof ? 19'd0 : count) + {18'd0, hit_p0};
  end

  assign frame_end = pix_valid && last_p0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col        <= '0;
      row        <= '0;
      sum_col    <= '0;
      sum_row    <= '0;
      count      <= '0;
      mask       <= 1'b0;
      mask_valid <= 1'b0;
    end else begin
      mask_valid <= pix_valid;
      if (pix_valid) begin
        mask <= hit_p0;
        col  <= col_nxt;
        row  <= row_nxt;
        if (last_p0) begin
          sum_col <= '0;
          sum_row <= '0;
          count   <= '0;
        end else begin
          sum_col <= sum_col_nxt;
          sum_row <= sum_row_nxt;
          count   <= count_nxt;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACCUM;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    div_done  = 1'b0;
    case (state)
      ACCUM: if (frame_end) state_nxt = DIV;
      DIV: begin
        if (step == STEPS) begin
          state_nxt = ACCUM;
          div_done  = 1'b1;
        end
      end
      default: state_nxt = ACCUM;
    endcase
  end

  assign busy      = (state == DIV);
  assign start_div = frame_end && (state == ACCUM);
  assign drop      = frame_end && (state == DIV);
  assign fin_found = (den >= CNT_MIN) && (den != 19'd0);

  // Divider stage: load at frame end, 28 quotient bits, then register the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_x        <= '0;
      rem_y        <= '0;
      quo_x        <= '0;
      quo_y        <= '0;
      den          <= '0;
      step         <= '0;
      cent_x       <= '0;
      cent_y       <= '0;
      blob_count   <= '0;
      found        <= 1'b0;
      result_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      result_valid <= div_done;
      overrun      <= drop;
      if (start_div) begin
        quo_x <= sum_col_nxt;
        quo_y <= sum_row_nxt;
        den   <= count_nxt;
        rem_x <= '0;
        rem_y <= '0;
        step  <= '0;
      end else if (busy && (step != STEPS)) begin
        {rem_x, quo_x} <= div_step(rem_x, quo_x, den);
        {rem_y, quo_y} <= div_step(rem_y, quo_y, den);
        step           <= step + 5'd1;
      end
      if (div_done) begin
        blob_count <= den;
        found      <= (den >= CNT_MIN);
        cent_x     <= fin_found ? sat_pos(quo_x) : 9'd0;
        cent_y     <= fin_found ? sat_pos(quo_y) : 9'd0;
      end
    end
  end

`ifdef RGB_CENTROID_BBOX_EN
  logic [8:0] bmin_col, bmax_col, bmin_row, bmax_row;
  logic [8:0] bmin_col_nxt, bmax_col_nxt, bmin_row_nxt, bmax_row_nxt;
  logic [8:0] hmin_col, hmax_col, hmin_row, hmax_row;
  logic [8:0] base_min_col, base_max_col, base_min_row, base_max_row;

  always_comb begin
    base_min_col = sof ? 9'h1FF : bmin_col;
    base_max_col = sof ? 9'd0   : bmax_col;
    base_min_row = sof ? 9'h1FF : bmin_row;
    base_max_row = sof ? 9'd0   : bmax_row;
    bmin_col_nxt = (hit_p0 && (pos_col_p0 < base_min_col)) ? pos_col_p0 : base_min_col;
    bmax_col_nxt = (hit_p0 && (pos_col_p0 > base_max_col)) ? pos_col_p0 : base_max_col;
    bmin_row_nxt = (hit_p0 && (pos_row_p0 < base_min_row)) ? pos_row_p0 : base_min_row;
    bmax_row_nxt = (hit_p0 && (pos_row_p0 > base_max_row)) ? pos_row_p0 : base_max_row;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bmin_col     <= 9'h1FF;
      bmax_col     <= '0;
      bmin_row     <= 9'h1FF;
      bmax_row     <= '0;
      hmin_col     <= '0;
      hmax_col     <= '0;
      hmin_row     <= '0;
      hmax_row     <= '0;
      bbox_min_col <= '0;
      bbox_max_col <= '0;
      bbox_min_row <= '0;
      bbox_max_row <= '0;
    end else begin
      if (pix_valid) begin
        bmin_col <= last_p0 ? 9'h1FF : bmin_col_nxt;
        bmax_col <= last_p0 ? 9'd0   : bmax_col_nxt;
        bmin_row <= last_p0 ? 9'h1FF : bmin_row_nxt;
        bmax_row <= last_p0 ? 9'd0   : bmax_row_nxt;
      end
      if (start_div) begin
        hmin_col <= bmin_col_nxt;
        hmax_col <= bmax_col_nxt;
        hmin_row <= bmin_row_nxt;
        hmax_row <= bmax_row_nxt;
      end
      if (div_done) begin
        bbox_min_col <= fin_found ? hmin_col : 9'd0;
        bbox_max_col <= fin_found ? hmax_col : 9'd0;
        bbox_min_row <= fin_found ? hmin_row : 9'd0;
        bbox_max_row <= fin_found ? hmax_row : 9'd0;
      end
    end
  end
`else
  assign bbox_min_col = '0;
  assign bbox_max_col = '0;
  assign bbox_min_row = '0;
  assign bbox_max_row = '0;
`endif

endmodule

// File: tb/tb_rgb_color_centroid.sv
// Bench for rgb_color_centroid: a 32x32 instance (MIN_COUNT=1) for frame results and masks,
// and a 4x2 instance (MIN_COUNT=4) streaming continuously to provoke overruns.
`timescale 1ns/1ps
module tb_rgb_color_centroid;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic       pix_valid, sof;
  logic [7:0] Rp, Gp, Bp;
  logic       mask, mask_valid, found, result_valid, busy, overrun;
  logic [8:0] cent_x, cent_y, bmin_c, bmax_c, bmin_r, bmax_r;
  logic [18:0] blob_count;

  logic       pv2, sof2;
  logic [7:0] r2, g2, b2;
  logic       mask2, mv2, found2, rv2, busy2, ov2;
  logic [8:0] cx2, cy2, bminc2, bmaxc2, bminr2, bmaxr2;
  logic [18:0] cnt2;

  rgb_color_centroid #(.WIDTH(32), .HEIGHT(32), .MIN_COUNT(1)) dut (
    .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .sof(sof), .Rp(Rp), .Gp(Gp), .Bp(Bp),
    .mask(mask), .mask_valid(mask_valid), .cent_x(cent_x), .cent_y(cent_y),
    .blob_count(blob_count), .found(found), .result_valid(result_valid), .busy(busy),
    .overrun(overrun), .bbox_min_col(bmin_c), .bbox_max_col(bmax_c),
    .bbox_min_row(bmin_r), .bbox_max_row(bmax_r));

  rgb_color_centroid #(.WIDTH(4), .HEIGHT(2), .MIN_COUNT(4)) dut_small (
    .clk(clk), .rst_n(rst_n), .pix_valid(pv2), .sof(sof2), .Rp(r2), .Gp(g2), .Bp(b2),
    .mask(mask2), .mask_valid(mv2), .cent_x(cx2), .cent_y(cy2),
    .blob_count(cnt2), .found(found2), .result_valid(rv2), .busy(busy2),
    .overrun(ov2), .bbox_min_col(bminc2), .bbox_max_col(bmaxc2),
    .bbox_min_row(bminr2), .bbox_max_row(bmaxr2));

  typedef struct {
    int cyc; int cx; int cy; int cnt; int fnd; int b0; int b1; int b2; int b3;
  } res_t;
  typedef struct {logic [7:0] r; logic [7:0] g; logic [7:0] b; logic hit;} vec_t;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   rv_cnt = 0;
  logic mask_q[$];
  res_t res_q[$];
  res_t res2_q[$];
  int   ov2_q[$];
  res_t em, es;
  logic [23:0] img[32][32];
  bit          hm[32][32];
  vec_t        tbl[8];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic res_t model(input int w, input int h, input int mincnt, input int ecyc);
    res_t m;
    int n = 0, sx = 0, sy = 0, mnx = 511, mxx = 0, mny = 511, mxy = 0;
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++)
        if (hm[r][c]) begin
          n++; sx += c; sy += r;
          if (c < mnx) mnx = c;
          if (c > mxx) mxx = c;
          if (r < mny) mny = r;
          if (r > mxy) mxy = r;
        end
    m = '{ecyc, 0, 0, n, 0, 0, 0, 0, 0};
    if (n >= mincnt && n > 0) begin
      m.fnd = 1; m.cx = sx / n; m.cy = sy / n;
`ifdef RGB_CENTROID_BBOX_EN
      m.b0 = mnx; m.b1 = mxx; m.b2 = mny; m.b3 = mxy;
`endif
    end
    return m;
  endfunction

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (mask_valid) begin
        if (mask_q.size() == 0) check("mask_unexpected", 64'(mask_valid), 64'(0));
        else check("mask", 64'(mask), 64'(mask_q.pop_front()));
      end
      if (overrun) check("main_overrun", 64'(overrun), 64'(0));
      if (result_valid) begin
        rv_cnt++;
        if (res_q.size() == 0) check("result_unexpected", 64'(result_valid), 64'(0));
        else begin
          em = res_q.pop_front();
          check("res_cycle", 64'(cyc), 64'(em.cyc));
          check("cent_x", 64'(cent_x), 64'(em.cx));
          check("cent_y", 64'(cent_y), 64'(em.cy));
          check("blob_count", 64'(blob_count), 64'(em.cnt));
          check("found", 64'(found), 64'(em.fnd));
          check("busy_at_result", 64'(busy), 64'(0));
          check("bbox", {28'd0, bmin_c, bmax_c, bmin_r, bmax_r},
                {28'd0, 9'(em.b0), 9'(em.b1), 9'(em.b2), 9'(em.b3)});
        end
      end
      if (ov2) begin
        if (ov2_q.size() == 0) check("overrun_unexpected", 64'(ov2), 64'(0));
        else check("overrun_cycle", 64'(cyc), 64'(ov2_q.pop_front()));
      end
      if (rv2) begin
        if (res2_q.size() == 0) check("small_result_unexpected", 64'(rv2), 64'(0));
        else begin
          es = res2_q.pop_front();
          check("small_cycle", 64'(cyc), 64'(es.cyc));
          check("small_cent", {46'd0, cx2, cy2}, {46'd0, 9'(es.cx), 9'(es.cy)});
          check("small_count", 64'(cnt2), 64'(es.cnt));
          check("small_found", 64'(found2), 64'(es.fnd));
          check("small_bbox", {28'd0, bminc2, bmaxc2, bminr2, bmaxr2},
                {28'd0, 9'(es.b0), 9'(es.b1), 9'(es.b2), 9'(es.b3)});
        end
      end
    end
  end

  task automatic pix(input logic s, input logic [23:0] rgb, input logic exp_hit);
    pix_valid = 1'b1; sof = s; {Rp, Gp, Bp} = rgb;
    mask_q.push_back(exp_hit);
    @(posedge clk); #1;
    pix_valid = 1'b0; sof = 1'b0;
  endtask

  task automatic pix2(input logic [23:0] rgb);
    pv2 = 1'b1; {r2, g2, b2} = rgb;
    @(posedge clk); #1;
    pv2 = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  task automatic clear_img();
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 32; c++) begin
        img[r][c] = ((r + c) % 3 == 0) ? 24'h7F0000 : 24'h000000;
        hm[r][c]  = 1'b0;
      end
  endtask

  task automatic place(input int c, input int r, input logic [23:0] rgb, input bit h);
    img[r][c] = rgb; hm[r][c] = h;
  endtask

  task automatic run_frame(input bit with_sof, input bit gaps, input bit expect_res);
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 32; c++) begin
        pix(with_sof && r == 0 && c == 0, img[r][c], hm[r][c]);
        if (gaps && ((r * 32 + c) % 97 == 50)) idle();
      end
    check("busy_after_frame", 64'(busy), 64'(1));
    if (expect_res) res_q.push_back(model(32, 32, 1, cyc + 29));
  endtask

  task automatic small_frame();
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 4; c++) pix2(img[r][c]);
  endtask

  task automatic wait_results();
    for (int i = 0; i < 100 && (res_q.size() != 0 || res2_q.size() != 0); i++) idle();
    check("result_timeout", 64'(res_q.size() + res2_q.size()), 64'(0));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int rv_saved;
    tbl[0] = '{8'd128, 8'd96, 8'd96, 1'b1};
    tbl[1] = '{8'd127, 8'd96, 8'd96, 1'b0};
    tbl[2] = '{8'd128, 8'd97, 8'd96, 1'b0};
    tbl[3] = '{8'd128, 8'd96, 8'd97, 1'b0};
    tbl[4] = '{8'd255, 8'd0,  8'd0,  1'b1};
    tbl[5] = '{8'd0,   8'd0,  8'd0,  1'b0};
    tbl[6] = '{8'd200, 8'd50, 8'd10, 1'b1};
    tbl[7] = '{8'd128, 8'd255, 8'd0, 1'b0};

    pix_valid = 0; sof = 0; Rp = 0; Gp = 0; Bp = 0;
    pv2 = 0; sof2 = 0; r2 = 0; g2 = 0; b2 = 0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cent", {46'd0, cent_x, cent_y}, 64'(0));
    check("rst_count", 64'(blob_count), 64'(0));
    check("rst_flags", {58'd0, mask, mask_valid, found, result_valid, busy, overrun}, 64'(0));
    check("rst_bbox", {28'd0, bmin_c, bmax_c, bmin_r, bmax_r}, 64'(0));
    check("rst_small", {25'd0, cx2, cy2, cnt2, found2, rv2, busy2, ov2}, 64'(0));
    rst_n = 1'b1;
    idle();

    // Continuous 4x2 frames: frames 2-4 end while the first division runs.
    clear_img();
    place(1, 0, 24'hFF0000, 1); place(2, 0, 24'h806060, 1);
    place(0, 1, 24'hC81E1E, 1); place(3, 1, 24'h900000, 1);
    small_frame();
    res2_q.push_back(model(4, 2, 4, cyc + 29));
    for (int f = 0; f < 3; f++) begin
      for (int r = 0; r < 2; r++)
        for (int c = 0; c < 4; c++) place(c, r, 24'hFF0000, 1);
      small_frame();
      ov2_q.push_back(cyc);
    end
    clear_img();
    place(0, 0, 24'hFF0000, 1); place(3, 0, 24'hFF0000, 1); place(3, 1, 24'hFF0000, 1);
    small_frame();
    res2_q.push_back(model(4, 2, 4, cyc + 29));
    wait_results();

    // All-black frame.
    clear_img();
    run_frame(1'b1, 1'b0, 1'b1);
    wait_results();

    // Single hit, with pix_valid gaps.
    clear_img();
    place(5, 7, 24'hC80A0A, 1);
    run_frame(1'b0, 1'b1, 1'b1);
    wait_results();

    // 2x2 block at cols 10-11, rows 20-21.
    clear_img();
    for (int r = 20; r < 22; r++)
      for (int c = 10; c < 12; c++) place(c, r, 24'h806060, 1);
    run_frame(1'b0, 1'b0, 1'b1);
    wait_results();

    // Threshold table along row 3 plus one extra hit.
    clear_img();
    for (int i = 0; i < 8; i++) place(i, 3, {tbl[i].r, tbl[i].g, tbl[i].b}, tbl[i].hit);
    place(12, 9, 24'h806060, 1);
    run_frame(1'b1, 1'b0, 1'b1);
    wait_results();

    // Corner pixels, last pixel of the frame itself a hit.
    clear_img();
    place(0, 0, 24'hFF0000, 1); place(31, 31, 24'hFF0000, 1);
    run_frame(1'b0, 1'b1, 1'b1);
    wait_results();

    // sof after three partial hits discards them.
    for (int i = 0; i < 3; i++) pix(1'b0, 24'hFF0000, 1'b1);
    pix(1'b0, 24'h000000, 1'b0);
    pix(1'b0, 24'h000000, 1'b0);
    clear_img();
    place(1, 1, 24'hFF0000, 1); place(2, 1, 24'hFF0000, 1);
    run_frame(1'b1, 1'b0, 1'b1);
    wait_results();

    // Reset during division step 10: the result is never delivered.
    clear_img();
    place(5, 5, 24'hFF0000, 1);
    run_frame(1'b0, 1'b0, 1'b0);
    repeat (10) idle();
    rv_saved = rv_cnt;
    rst_n = 1'b0;
    #1;
    check("midrst_flags", {61'd0, busy, result_valid, found}, 64'(0));
    check("midrst_out", {37'd0, cent_x, cent_y, blob_count}, 64'(0));
    idle();
    rst_n = 1'b1;
    repeat (40) idle();
    check("midrst_no_result", 64'(rv_cnt), 64'(rv_saved));
    check("midrst_busy", 64'(busy), 64'(0));

    for (int i = 0; i < 50 && (mask_q.size() != 0 || ov2_q.size() != 0); i++) idle();
    check("leftover_mask", 64'(mask_q.size()), 64'(0));
    check("leftover_overrun", 64'(ov2_q.size()), 64'(0));
    check("leftover_result", 64'(res_q.size() + res2_q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/rgb_color_centroid.md
Name: rgb_color_centroid

Overview:
- Downstream consumer of the RGB pixel stream produced by the image-memory reader (Rp/Gp/Bp, one pixel per clock, row-major).
- Classifies each pixel against a programmable colour box, emitting a 1-bit mask, and accumulates mask coordinates per frame.
- At frame end, a sequential restoring divider computes the blob centroid for the robot tracking logic.
- Accumulation of the next frame continues while the divider runs.

Parameters:
- WIDTH, 32, pixels per row (column counter wraps at WIDTH-1).
- HEIGHT, 32, rows per frame (row counter wraps at HEIGHT-1).
- R_MIN, 128, inclusive lower bound on R for a hit.
- G_MAX, 96, inclusive upper bound on G for a hit.
- B_MAX, 96, inclusive upper bound on B for a hit.
- MIN_COUNT, 4, minimum hit count for found=1.

Ports:
- clk in 1: system clock, all logic on rising edge.
- rst_n in 1: asynchronous, active-low reset.
- pix_valid in 1: Rp/Gp/Bp carry a pixel this cycle.
- sof in 1: first pixel of frame, qualified by pix_valid.
- Rp in 8, Gp in 8, Bp in 8: pixel colour.
- mask out 1: registered hit flag for the last accepted pixel.
- mask_valid out 1: registered copy of pix_valid.
- cent_x out 9: centroid column, floor(sum_col/count).
- cent_y out 9: centroid row, floor(sum_row/count).
- blob_count out 19: hit count of the reported frame.
- found out 1: blob_count >= MIN_COUNT.
- result_valid out 1: one-cycle pulse; result outputs valid from this cycle until the next pulse.
- busy out 1: divider running.
- overrun out 1: one-cycle pulse when a frame result is dropped.
- bbox_min_col/bbox_max_col out 9, bbox_min_row/bbox_max_row out 9: see Optional Feature.

Behaviour:
- Reset (async assert, sync release): every output is 0; col=0, row=0; accumulators 0; state ACCUM.
- Hit rule: (Rp>=R_MIN) && (Gp<=G_MAX) && (Bp<=B_MAX). mask/mask_valid have 1-cycle latency.
- Position: col (9b) and row (9b) are tagged on each accepted pixel.
  - sof forces the current pixel to col=0,row=0 and discards the partial sums first.
  - Otherwise col increments; at WIDTH-1 it wraps to 0 and row increments; at row=HEIGHT-1,col=WIDTH-1 both wrap to 0 (free-running frames, sof optional).
- Accumulators: sum_col 28b, sum_row 28b, count 19b. Add col/row/1 on hit; no saturation needed within widths.
- Last pixel (col=WIDTH-1,row=HEIGHT-1) on accepting edge E0:
  - Final sums, including that pixel, are snapshotted.
  - Accumulators clear, so the next pixel starts a fresh frame.
  - If state ACCUM: go DIV, busy=1.
  - If already DIV: snapshot discarded, overrun pulses at E0+1, current division unaffected.
- DIV: two parallel 28-step restoring dividers, one quotient bit per edge (E1..E28).
  - At E29: cent_x/cent_y/blob_count/found registered, result_valid=1 for one cycle, busy=0, state ACCUM.
  - Fixed latency regardless of count.
- count < MIN_COUNT (incl. 0): found=0, cent_x=cent_y=0. Division by zero never propagates.
- Quotients are truncated to 9 bits; upper bits are zero by construction.
- sof during DIV: affects accumulation only, never the running division.
- pix_valid=0: counters and accumulators hold; the divider keeps running.
- Reset mid-DIV: result discarded, result_valid never pulses for that frame.

Optional Feature:
- Macro: RGB_CENTROID_BBOX_EN.
- Defined:
  - Per-frame min/max col and row of hits are tracked.
  - Trackers reset to min=511,max=0 at frame start.
  - Values are snapshotted with the sums and registered to bbox_* at the result_valid edge.
  - If found=0, all bbox_* outputs are 0.
- Undefined: bbox_* tied to 0, no tracking registers.

Test Plan:
- All-black 32x32 frame -> result_valid 29 edges after last pixel; blob_count=0, found=0, cent_x=cent_y=0.
- MIN_COUNT=1, single hit at col=5,row=7 -> cent_x=5, cent_y=7, blob_count=1, found=1; with BBOX_EN all bbox bounds 5/7.
- Hits at cols 10-11, rows 20-21 (4 px) -> cent_x=10 (floor 42/4), cent_y=20, blob_count=4, found=1.
- Threshold edges (R=128,G=96,B=96) -> mask=1 next cycle; R=127 or G=97 -> mask=0.
- sof mid-frame after 3 hits, then 2 hits at col 1,row 1 -> blob_count=2, earlier hits excluded; reset asserted at DIV step 10 -> outputs 0, no result_valid.
- WIDTH=4, HEIGHT=2, continuous pixels -> second frame ends at E0+8 while busy: overrun pulse; first result still delivered correctly.
